// File: rtl/tdm_demux4_if.sv
// Bus between a TDM sample source and the tdm_demux4 receiver.
// The source drives master; the demux uses slave.
interface tdm_demux4_if #(parameter int WIDTH = 1);
  logic                 din_valid;
  logic                 sof;
  logic [WIDTH-1:0]     din;
  logic [4*WIDTH-1:0]   dout;
  logic                 frame_valid;
  logic [1:0]           sel;
  logic                 locked;
  logic                 sync_err;

  modport master (output din_valid, sof, din,
                  input  dout, frame_valid, sel, locked, sync_err);
  modport slave  (input  din_valid, sof, din,
                  output dout, frame_valid, sel, locked, sync_err);
endinterface

// File: rtl/tdm_demux4.sv
// 1:4 TDM demux: collects lanes 0..3 into shadow regs, publishes whole frames atomically.
// Optional TDM_DEMUX_STRICT_SOF_EN: a lane-0 beat without sof while locked drops lock.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  tdm_demux4_if.slave   bus
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic [2:0][WIDTH-1:0]   shd_q, shd_d;
  logic [3:0][WIDTH-1:0]   dout_q, dout_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      shd_q   <= '0;
      dout_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      shd_q   <= shd_d;
      dout_q  <= dout_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    shd_d   = shd_q;
    dout_d  = dout_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.sof) begin
            shd_d[0] = bus.din;
            sel_d    = 2'd1;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (bus.sof && sel_q != 2'd0) begin
            // Early sof: restart the frame with this beat as lane 0.
            err_d    = 1'b1;
            shd_d[0] = bus.din;
            sel_d    = 2'd1;
          end
`ifdef TDM_DEMUX_STRICT_SOF_EN
          else if (!bus.sof && sel_q == 2'd0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
`endif
          else begin
            case (sel_q)
              2'd0: shd_d[0] = bus.din;
              2'd1: shd_d[1] = bus.din;
              2'd2: shd_d[2] = bus.din;
              default: begin
                dout_d = {bus.din, shd_q[2], shd_q[1], shd_q[0]};
                fv_d   = 1'b1;
              end
            endcase
            sel_d = sel_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = fv_q;
  assign bus.sel         = sel_q;
  assign bus.locked      = (state_q == RUN);
  assign bus.sync_err    = err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: WIDTH=4 and WIDTH=1 instances share one stimulus stream
// (the narrow one sees bit 0 of each sample); checked by table and a queue-based model.
module tb_tdm_demux4;
`ifdef TDM_DEMUX_STRICT_SOF_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_demux4_if #(.WIDTH(4)) bus4 ();
  tdm_demux4_if #(.WIDTH(1)) bus1 ();

  tdm_demux4 #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  tdm_demux4 #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_pass = 0;
  int n_tot  = 0;
  int fcnt   = 0;

  // Reference model: samples of the frame in progress, plus last published frame.
  logic [3:0]  m_q[$];
  logic        m_lock = 1'b0;
  logic [15:0] m_dout = '0;
  logic        m_fv = 1'b0;
  logic        m_err = 1'b0;

  function automatic logic [3:0] narrow(input logic [15:0] f);
    return {f[12], f[8], f[4], f[0]};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model(input logic r, input logic v, input logic s, input logic [3:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_q.delete();
      m_lock = 1'b0;
      m_dout = '0;
    end else if (v) begin
      if (!m_lock) begin
        if (s) begin m_q = '{d}; m_lock = 1'b1; end
      end else if (s && m_q.size() != 0) begin
        m_err = 1'b1;
        m_q = '{d};
      end else if (!s && m_q.size() == 0 && STRICT) begin
        m_err  = 1'b1;
        m_lock = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          m_dout = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_fv   = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    rst = r;
    bus4.din_valid = v; bus4.sof = s; bus4.din = d;
    bus1.din_valid = v; bus1.sof = s; bus1.din = d[0];
    @(posedge clk);
    model(r, v, s, d);
    #1;
    if (bus4.frame_valid) fcnt++;
  endtask

  task automatic chk_model();
    logic [1:0] esel;
    esel = m_lock ? 2'(m_q.size()) : 2'd0;
    chk("dout",   bus4.dout,                 m_dout);
    chk("fvalid", 16'(bus4.frame_valid),     16'(m_fv));
    chk("syncerr",16'(bus4.sync_err),        16'(m_err));
    chk("sel",    16'(bus4.sel),             16'(esel));
    chk("locked", 16'(bus4.locked),          16'(m_lock));
    chk("dout_w1",16'(bus1.dout),            16'(narrow(m_dout)));
    chk("fv_w1",  16'(bus1.frame_valid),     16'(m_fv));
  endtask

  task automatic mstep(input logic r, input logic v, input logic s, input logic [3:0] d);
    step(r, v, s, d);
    chk_model();
  endtask

  typedef struct {
    logic r, v, s; logic [3:0] d;
    logic efv, eerr, elock; logic [1:0] esel; logic [15:0] edout;
  } vec_t;

  function automatic vec_t mk(input logic r, v, s, input logic [3:0] d,
                              input logic efv, eerr, elock, input logic [1:0] esel,
                              input logic [15:0] edout);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d;
    t.efv = efv; t.eerr = eerr; t.elock = elock; t.esel = esel; t.edout = edout;
    return t;
  endfunction

  initial begin
    vec_t tv[$];
    int f0;

    bus4.din_valid = 1'b0; bus4.sof = 1'b0; bus4.din = '0;
    bus1.din_valid = 1'b0; bus1.sof = 1'b0; bus1.din = '0;

    // Reset, frame 1,0,1,1, then early-sof sequence.
    tv.push_back(mk(1,0,0,4'h0, 0,0,0,2'd0,16'h0000));
    tv.push_back(mk(0,1,1,4'h1, 0,0,1,2'd1,16'h0000));
    tv.push_back(mk(0,1,0,4'h0, 0,0,1,2'd2,16'h0000));
    tv.push_back(mk(0,1,0,4'h1, 0,0,1,2'd3,16'h0000));
    tv.push_back(mk(0,1,0,4'h1, 1,0,1,2'd0,16'h1101));
    tv.push_back(mk(0,0,0,4'h0, 0,0,1,2'd0,16'h1101));
    tv.push_back(mk(0,1,1,4'h1, 0,0,1,2'd1,16'h1101));
    tv.push_back(mk(0,1,0,4'h2, 0,0,1,2'd2,16'h1101));
    tv.push_back(mk(0,1,1,4'h7, 0,1,1,2'd1,16'h1101));
    tv.push_back(mk(0,1,0,4'h8, 0,0,1,2'd2,16'h1101));
    tv.push_back(mk(0,1,0,4'h9, 0,0,1,2'd3,16'h1101));
    tv.push_back(mk(0,1,0,4'hA, 1,0,1,2'd0,16'hA987));
    tv.push_back(mk(0,0,0,4'h0, 0,0,1,2'd0,16'hA987));
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].v, tv[i].s, tv[i].d);
      chk("t_dout",   bus4.dout,                tv[i].edout);
      chk("t_fvalid", 16'(bus4.frame_valid),    16'(tv[i].efv));
      chk("t_syncerr",16'(bus4.sync_err),       16'(tv[i].eerr));
      chk("t_sel",    16'(bus4.sel),            16'(tv[i].esel));
      chk("t_locked", 16'(bus4.locked),         16'(tv[i].elock));
      chk("t_dout_w1",16'(bus1.dout),           16'(narrow(tv[i].edout)));
    end

    // Gapped frame with two idle cycles between samples.
    mstep(1,0,0,4'h0);
    f0 = fcnt;
    mstep(0,1,1,4'hA); mstep(0,0,0,4'h0); mstep(0,0,0,4'h0);
    mstep(0,1,0,4'hB); mstep(0,0,0,4'h0); mstep(0,0,0,4'h0);
    mstep(0,1,0,4'hC); mstep(0,0,0,4'h0); mstep(0,0,0,4'h0);
    mstep(0,1,0,4'hD);
    for (int i = 0; i < 3; i++) mstep(0,0,0,4'h0);
    chk("gap_dout", bus4.dout, 16'hDCBA);
    chk("gap_frames", 16'(fcnt - f0), 16'd1);

    // Beats without sof in IDLE are dropped; a later sof frame still decodes.
    mstep(1,0,0,4'h0);
    f0 = fcnt;
    for (int i = 0; i < 4; i++) mstep(0,1,0,4'(i + 5));
    chk("idle_frames", 16'(fcnt - f0), 16'd0);
    chk("idle_locked", 16'(bus4.locked), 16'd0);
    mstep(0,1,1,4'h3); mstep(0,1,0,4'h5); mstep(0,1,0,4'h7); mstep(0,1,0,4'h9);
    chk("idle_then_dout", bus4.dout, 16'h9753);

    // Reset mid-frame discards the partial frame.
    mstep(0,1,1,4'h1); mstep(0,1,0,4'h2);
    f0 = fcnt;
    mstep(1,1,0,4'h3);
    chk("mrst_dout", bus4.dout, 16'h0000);
    chk("mrst_sel", 16'(bus4.sel), 16'd0);
    chk("mrst_locked", 16'(bus4.locked), 16'd0);
    mstep(0,1,1,4'h4); mstep(0,1,0,4'h5); mstep(0,1,0,4'h6); mstep(0,1,0,4'h7);
    chk("mrst_frames", 16'(fcnt - f0), 16'd1);
    chk("mrst_dout2", bus4.dout, 16'h7654);

    // Back-to-back frames, second without sof.
    f0 = fcnt;
    mstep(0,1,1,4'h1); mstep(0,1,0,4'h2); mstep(0,1,0,4'h3); mstep(0,1,0,4'h4);
    mstep(0,1,0,4'h5); mstep(0,1,0,4'h6); mstep(0,1,0,4'h7); mstep(0,1,0,4'h8);
    mstep(0,0,0,4'h0);
    chk("nosof_frames", 16'(fcnt - f0), STRICT ? 16'd1 : 16'd2);
    chk("nosof_locked", 16'(bus4.locked), STRICT ? 16'd0 : 16'd1);
    chk("nosof_dout", bus4.dout, STRICT ? 16'h4321 : 16'h8765);

    // Randomised traffic against the model.
    mstep(1,0,0,4'h0);
    for (int i = 0; i < 600; i++) begin
      logic r, v, s;
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 70);
      s = ($urandom_range(0, 99) < 20);
      mstep(r, v, s, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
